// File: rtl/fetch_mem_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between the I-cache and D-cache miss controllers.
// A grant is held until pmem_resp, and the response is routed back to the winner in the same cycle.
module fetch_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 256,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,
    output logic [CNT_WIDTH-1:0]  i_grant_cnt,
    output logic [CNT_WIDTH-1:0]  d_grant_cnt
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_I = 2'd1;
    localparam logic [1:0] SERVE_D = 2'd2;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       last_grant;
    logic       last_grant_nxt;
    logic       d_pend;

    assign d_pend = d_read | d_write;

    // State and round-robin history; async reset drops every strobe immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GRANT_D;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Next state, memory strobes and response routing.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        pmem_read      = 1'b0;
        pmem_write     = 1'b0;
        pmem_address   = '0;
        pmem_wdata     = '0;
        i_resp         = 1'b0;
        i_rdata        = '0;
        d_resp         = 1'b0;
        d_rdata        = '0;

        case (state)
            IDLE: begin
                if (i_read && d_pend) begin
                    state_nxt = (last_grant == GRANT_D) ? SERVE_I : SERVE_D;
                end else if (i_read) begin
                    state_nxt = SERVE_I;
                end else if (d_pend) begin
                    state_nxt = SERVE_D;
                end
            end

            SERVE_I: begin
                pmem_read    = 1'b1;
                pmem_address = i_address;
                if (pmem_resp) begin
                    i_resp         = 1'b1;
                    i_rdata        = pmem_rdata;
                    last_grant_nxt = GRANT_I;
                    state_nxt      = IDLE;
                end
            end

            SERVE_D: begin
                pmem_address = d_address;
                // A writeback wins if both strobes are (illegally) raised together.
                if (d_write) begin
                    pmem_write = 1'b1;
                    pmem_wdata = d_wdata;
                end else if (d_read) begin
                    pmem_read = 1'b1;
                end
                if (pmem_resp) begin
                    d_resp         = 1'b1;
                    d_rdata        = pmem_rdata;
                    last_grant_nxt = GRANT_D;
                    state_nxt      = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Completed-transfer counters, wrapping naturally at 2^CNT_WIDTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_grant_cnt <= '0;
            d_grant_cnt <= '0;
        end else begin
            if (i_resp) begin
                i_grant_cnt <= i_grant_cnt + CNT_WIDTH'(1);
            end
            if (d_resp) begin
                d_grant_cnt <= d_grant_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // The data cache must never read and write back in the same request.
    always @(posedge clk) begin
        if (!rst && state == SERVE_D) begin
            assert (!(d_read && d_write));
        end
    end

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Directed bench for fetch_mem_arbiter with hand-computed expectations; counters built 4 bits wide to reach wrap.
module tb_fetch_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 256;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read;
    logic [AW-1:0] i_address;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_address;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;
    logic [CW-1:0] i_grant_cnt;
    logic [CW-1:0] d_grant_cnt;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    localparam logic [AW-1:0] I_ADDR = 32'h8000_0000;
    localparam logic [AW-1:0] D_ADDR = 32'h8000_1000;
    localparam logic [LW-1:0] PAT_A5 = {32{8'hA5}};
    localparam logic [LW-1:0] PAT_WB = {8{32'h1234_5678}};
    localparam logic [LW-1:0] PAT_5A = {32{8'h5A}};

    fetch_mem_arbiter #(
        .ADDR_WIDTH(AW),
        .LINE_WIDTH(LW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_read      (i_read),
        .i_address   (i_address),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_address   (d_address),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .pmem_read   (pmem_read),
        .pmem_write  (pmem_write),
        .pmem_address(pmem_address),
        .pmem_wdata  (pmem_wdata),
        .pmem_rdata  (pmem_rdata),
        .pmem_resp   (pmem_resp),
        .i_grant_cnt (i_grant_cnt),
        .d_grant_cnt (d_grant_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        i_read     = 1'b0;
        i_address  = '0;
        d_read     = 1'b0;
        d_write    = 1'b0;
        d_address  = '0;
        d_wdata    = '0;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;
        step();
        step();
        #2;
        check("rst_pmem_read", LW'(pmem_read), LW'(0));
        check("rst_i_cnt", LW'(i_grant_cnt), LW'(0));
        rst = 1'b0;

        // Idle with no requests.
        repeat (10) step();
        #2;
        check("idle_strobes", LW'({pmem_read, pmem_write, i_resp, d_resp}), LW'(0));
        check("idle_addr", LW'(pmem_address), LW'(0));
        check("idle_state", LW'(dut.state), LW'(0));
        check("idle_cnts", LW'({i_grant_cnt, d_grant_cnt}), LW'(0));

        // Stray pmem_resp in IDLE is ignored.
        pmem_resp  = 1'b1;
        pmem_rdata = PAT_5A;
        #1;
        check("stray_resp", LW'({i_resp, d_resp}), LW'(0));
        step();
        pmem_resp = 1'b0;
        #2;
        check("stray_cnts", LW'({i_grant_cnt, d_grant_cnt}), LW'(0));

        // Instruction read alone, response after five cycles.
        i_read    = 1'b1;
        i_address = I_ADDR;
        #2;
        check("i_pre_grant", LW'(pmem_read), LW'(0));
        step();
        #2;
        check("i_grant_read", LW'(pmem_read), LW'(1));
        check("i_grant_addr", LW'(pmem_address), LW'(I_ADDR));
        repeat (4) step();
        #2;
        check("i_hold_read", LW'(pmem_read), LW'(1));
        pmem_resp  = 1'b1;
        pmem_rdata = PAT_A5;
        #1;
        check("i_resp", LW'({i_resp, d_resp}), LW'(2'b10));
        check("i_rdata", i_rdata, PAT_A5);
        step();
        i_read    = 1'b0;
        pmem_resp = 1'b0;
        #2;
        check("i_resp_pulse", LW'(i_resp), LW'(0));
        check("i_bubble", LW'(pmem_read), LW'(0));
        check("i_cnt1", LW'(i_grant_cnt), LW'(1));

        // Data writeback alone.
        d_write   = 1'b1;
        d_address = D_ADDR;
        d_wdata   = PAT_WB;
        step();
        #2;
        check("d_wr_strobes", LW'({pmem_read, pmem_write}), LW'(2'b01));
        check("d_wr_addr", LW'(pmem_address), LW'(D_ADDR));
        check("d_wr_wdata", pmem_wdata, PAT_WB);
        step();
        pmem_resp  = 1'b1;
        pmem_rdata = PAT_5A;
        #2;
        check("d_wr_resp", LW'({i_resp, d_resp}), LW'(2'b01));
        step();
        d_write   = 1'b0;
        pmem_resp = 1'b0;
        #2;
        check("d_cnt1", LW'({i_grant_cnt, d_grant_cnt}), LW'({4'd1, 4'd1}));
        check("d_wr_done", LW'(pmem_write), LW'(0));

        // Simultaneous reads after reset, both held: I first, then strictly alternating.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        i_read = 1'b1;
        d_read = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            #2;
            check($sformatf("rr%0d_addr", k), LW'(pmem_address), (k % 2 == 0) ? LW'(I_ADDR) : LW'(D_ADDR));
            check($sformatf("rr%0d_read", k), LW'(pmem_read), LW'(1));
            pmem_resp  = 1'b1;
            pmem_rdata = (k % 2 == 0) ? PAT_A5 : PAT_5A;
            #1;
            check($sformatf("rr%0d_resp", k), LW'({i_resp, d_resp}), (k % 2 == 0) ? LW'(2'b10) : LW'(2'b01));
            step();
            pmem_resp = 1'b0;
            #2;
            check($sformatf("rr%0d_bubble", k), LW'(pmem_read), LW'(0));
        end
        check("rr_cnts", LW'({i_grant_cnt, d_grant_cnt}), LW'({4'd3, 4'd3}));
        i_read = 1'b0;
        d_read = 1'b0;
        step();

        // Reset mid-writeback, then a late response for the aborted transfer.
        d_write = 1'b1;
        step();
        #2;
        check("abort_write_on", LW'(pmem_write), LW'(1));
        rst = 1'b1;
        #1;
        check("abort_write_off", LW'(pmem_write), LW'(0));
        check("abort_cnts", LW'({i_grant_cnt, d_grant_cnt}), LW'(0));
        step();
        rst     = 1'b0;
        d_write = 1'b0;
        step();
        pmem_resp = 1'b1;
        #2;
        check("abort_late_resp", LW'(d_resp), LW'(0));
        step();
        pmem_resp = 1'b0;
        #2;
        check("abort_late_cnt", LW'(d_grant_cnt), LW'(0));

        // Seventeen instruction transfers wrap the 4-bit counter to 1.
        for (int k = 0; k < 17; k++) begin
            i_read = 1'b1;
            step();
            pmem_resp = 1'b1;
            step();
            pmem_resp = 1'b0;
            i_read    = 1'b0;
            if (k == 15) begin
                #2;
                check("wrap_cnt16", LW'(i_grant_cnt), LW'(0));
            end
        end
        #2;
        check("wrap_cnt17", LW'(i_grant_cnt), LW'(1));
        check("wrap_d_cnt", LW'(d_grant_cnt), LW'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
